umem_arb: RTL and testbench
===========================

# umem_arb

Unified-memory arbiter for the five-stage pipeline: shares one single-port memory between the fetch stage (instruction reads) and the memory stage (data loads/stores). Grants one requester at a time through a small FSM, with data priority and an optional anti-starvation counter. Drives a pipeline pause while any request is outstanding, and suppresses the fetch response when fetch is cancelled by a taken branch.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while a fetch waits (used only with UMEM_ARB_FAIR_EN); legal range 1..15.

Ports:
- clk  in  1  clock; all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- i_ARB_iReq  in  1  fetch request; held until o_ARB_iAck
- i_ARB_iAddr  in  32  fetch byte address; bits [1:0] ignored
- i_ARB_iKill  in  1  cancel the current or pending fetch (branch flush)
- o_ARB_iAck  out  1  fetch done, one-cycle pulse
- o_ARB_iRdata  out  32  instruction word; valid while o_ARB_iAck is high
- i_ARB_dReq  in  1  data request; held until o_ARB_dAck
- i_ARB_dWe  in  1  1 = store, 0 = load
- i_ARB_dByte  in  1  1 = byte access, 0 = word access
- i_ARB_dAddr  in  32  data byte address
- i_ARB_dWdata  in  32  store data; byte stores use bits [7:0]
- o_ARB_dAck  out  1  data done, one-cycle pulse
- o_ARB_dRdata  out  32  load data; valid while o_ARB_dAck is high
- o_ARB_pause  out  1  pipeline stall
- o_ARB_mReq  out  1  memory request
- o_ARB_mWe  out  1  memory write
- o_ARB_mBe  out  4  byte enables
- o_ARB_mAddr  out  32  word address {addr[31:2],2'b00}
- o_ARB_mWdata  out  32  write data
- i_ARB_mRdata  in  32  read data; valid when i_ARB_mAck is high
- i_ARB_mAck  in  1  memory completes the access this cycle

## Operation
- FSM states: IDLE, GNT_I, GNT_D, RESP_I, RESP_D.
- IDLE:
  - grant data if i_ARB_dReq is high; otherwise grant fetch if i_ARB_iReq is high and i_ARB_iKill is low.
  - On both requests: data wins, except when the fairness rule applies (see Configuration).
- GNT_x:
  - o_ARB_mReq = 1 with fields registered at grant; fields stay stable until i_ARB_mAck.
  - On i_ARB_mAck: capture rdata, go to RESP_x.
- RESP_x:
  - o_ARB_xAck = 1 for exactly one cycle, then go to IDLE.
  - A request seen in IDLE after RESP is a new request. Requesters drop or change req on the edge that ends the ack cycle.
- Fetch kill:
  - i_ARB_iKill high in any cycle of GNT_I sets a killed flag. The memory access still completes, but RESP_I produces no o_ARB_iAck and o_ARB_iRdata keeps its previous value.
  - The flag clears on return to IDLE.
- Store: o_ARB_mWe = 1.
  - Word store: mBe = 4'b1111, mWdata = dWdata.
  - Byte store: mBe = 4'b0001 << addr[1:0], with dWdata[7:0] replicated to all four lanes.
- Byte load: o_ARB_dRdata = zero-extended lane addr[1:0] of mRdata. Word load returns the full word.
- Fetch always uses mWe = 0, mBe = 4'b1111.
- o_ARB_pause (combinational) = (i_ARB_iReq & ~i_ARB_iKill & ~o_ARB_iAck) | (i_ARB_dReq & ~o_ARB_dAck).

## Timing
- Reset values:
  - state = IDLE
  - o_ARB_mReq, o_ARB_mWe, o_ARB_iAck, o_ARB_dAck = 0
  - o_ARB_mBe = 0; mAddr, mWdata, iRdata, dRdata = 0
  - starvation counter = 0
- Latency: request seen in IDLE at cycle 0 → mReq high from cycle 1 → i_ARB_mAck at cycle k ≥ 1 → ack at cycle k+1.
  - Minimum 2 cycles from request to ack; back-to-back throughput is one access per 3 cycles.
- i_ARB_mAck is ignored outside GNT_x. i_ARB_mAck in the same cycle mReq rises is legal (k = 1).
- Reset mid-transaction: immediate return to IDLE and mReq drops. The memory backend shares rstn and discards the access.
- Requests arriving while another access is active wait; pause stays high for them.

## Configuration
- UMEM_ARB_FAIR_EN defined:
  - A counter (4 bits, saturating) increments on each data grant made while i_ARB_iReq & ~i_ARB_iKill is high.
  - It clears on any fetch grant, or on any IDLE cycle where the fetch request is absent.
  - When counter == STARVE_MAX and both requests are present in IDLE, fetch is granted.
- UMEM_ARB_FAIR_EN undefined: strict data priority, no counter logic; fetch can starve indefinitely.

## Test plan
- Word fetch, addr 0x0000_0104, memory acks at cycle 1 with 0x2402_0005 → mAddr 0x104, mBe 4'hF; iAck high at cycle 2 with iRdata 0x2402_0005; pause high for cycles 0–1, then low.
- Byte store, addr 0x...203, wdata 0x0000_00AB → mBe 4'b1000, mWdata 0xABAB_ABAB, mWe 1. A following byte load at the same address with mRdata 0xAB00_0000 → dRdata 0x0000_00AB.
- Both requests at cycle 0 → data granted first; fetch granted in the IDLE cycle after RESP_D; each ack pulses exactly once.
- iKill pulsed during GNT_I with memory latency 3 → mReq completes, no iAck; a new fetch afterward proceeds normally.
- Fairness on, STARVE_MAX = 2, both requests held continuously → grant order D, D, I, D, D, I. Fairness off → D repeatedly while dReq is held.
- rstn low during GNT_D → mReq = 0 and state IDLE asynchronously; no ack after reset release.

Source files
------------

// File: rtl/umem_arb_if.sv
// umem_arb_if -- bus bundle for the unified-memory arbiter.
//   Fetch side : i_ARB_iReq/iAddr/iKill in, o_ARB_iAck/iRdata out
//   Data side  : i_ARB_dReq/dWe/dByte/dAddr/dWdata in, o_ARB_dAck/dRdata out
//   Pipeline   : o_ARB_pause out
//   Memory side: o_ARB_mReq/mWe/mBe/mAddr/mWdata out, i_ARB_mRdata/mAck in
// Modports: slave = the arbiter itself, master = everything around it
// (pipeline requesters plus the memory backend).
interface umem_arb_if;
    logic        i_ARB_iReq;
    logic [31:0] i_ARB_iAddr;
    logic        i_ARB_iKill;
    logic        o_ARB_iAck;
    logic [31:0] o_ARB_iRdata;
    logic        i_ARB_dReq;
    logic        i_ARB_dWe;
    logic        i_ARB_dByte;
    logic [31:0] i_ARB_dAddr;
    logic [31:0] i_ARB_dWdata;
    logic        o_ARB_dAck;
    logic [31:0] o_ARB_dRdata;
    logic        o_ARB_pause;
    logic        o_ARB_mReq;
    logic        o_ARB_mWe;
    logic [3:0]  o_ARB_mBe;
    logic [31:0] o_ARB_mAddr;
    logic [31:0] o_ARB_mWdata;
    logic [31:0] i_ARB_mRdata;
    logic        i_ARB_mAck;

    modport slave (
        input  i_ARB_iReq, i_ARB_iAddr, i_ARB_iKill,
        output o_ARB_iAck, o_ARB_iRdata,
        input  i_ARB_dReq, i_ARB_dWe, i_ARB_dByte, i_ARB_dAddr, i_ARB_dWdata,
        output o_ARB_dAck, o_ARB_dRdata, o_ARB_pause,
        output o_ARB_mReq, o_ARB_mWe, o_ARB_mBe, o_ARB_mAddr, o_ARB_mWdata,
        input  i_ARB_mRdata, i_ARB_mAck
    );

    modport master (
        output i_ARB_iReq, i_ARB_iAddr, i_ARB_iKill,
        input  o_ARB_iAck, o_ARB_iRdata,
        output i_ARB_dReq, i_ARB_dWe, i_ARB_dByte, i_ARB_dAddr, i_ARB_dWdata,
        input  o_ARB_dAck, o_ARB_dRdata, o_ARB_pause,
        input  o_ARB_mReq, o_ARB_mWe, o_ARB_mBe, o_ARB_mAddr, o_ARB_mWdata,
        output i_ARB_mRdata, i_ARB_mAck
    );
endinterface

// File: rtl/umem_arb.sv
// umem_arb -- shares one single-port memory between instruction fetch and
// the data stage. One access at a time: IDLE -> GNT_x -> RESP_x -> IDLE.
// Data has priority; fetch responses are dropped when killed by a branch.
// Ports:
//   clk   : clock, all state on rising edge
//   rstn  : asynchronous active-low reset
//   bus   : umem_arb_if.slave (fetch, data, pause and memory signals)
// Parameter STARVE_MAX: data grants tolerated while a fetch waits.
// Optional feature: define UMEM_ARB_FAIR_EN to enable the anti-starvation
// counter; without it data priority is strict.
module umem_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic      clk,
    input  logic      rstn,
    umem_arb_if.slave bus
);
    typedef enum logic [2:0] {IDLE, GNT_I, GNT_D, RESP_I, RESP_D} state_t;

    state_t      state_q, state_d;
    logic        mWe_q, mWe_d;
    logic [3:0]  mBe_q, mBe_d;
    logic [31:0] mAddr_q, mAddr_d;
    logic [31:0] mWdata_q, mWdata_d;
    logic [1:0]  lane_q, lane_d;
    logic        byte_q, byte_d;
    logic [31:0] iRdata_q, iRdata_d;
    logic [31:0] dRdata_q, dRdata_d;
    logic        killed_q, killed_d;

    logic        fetch_v, fair_fetch, gnt_i, gnt_d;
    logic [7:0]  ld_byte;
    logic        unused_addr_bits;

    // Byte offset of a fetch is meaningless: fetches are always whole words.
    assign unused_addr_bits = ^bus.i_ARB_iAddr[1:0];

    assign fetch_v = bus.i_ARB_iReq & ~bus.i_ARB_iKill;

`ifdef UMEM_ARB_FAIR_EN
    logic [3:0] cnt_q, cnt_d;

    assign fair_fetch = fetch_v & (cnt_q == 4'(STARVE_MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (gnt_i || (state_q == IDLE && !fetch_v))
            cnt_d = '0;
        else if (gnt_d && fetch_v && cnt_q != 4'hF)
            cnt_d = cnt_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    localparam logic [3:0] STARVE_MAX_UNUSED = 4'(STARVE_MAX);
    assign fair_fetch = 1'b0;
`endif

    // Data wins unless the starvation limit hands the slot to fetch.
    assign gnt_d = (state_q == IDLE) & bus.i_ARB_dReq & ~fair_fetch;
    assign gnt_i = (state_q == IDLE) & fetch_v & (~bus.i_ARB_dReq | fair_fetch);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_d) state_d = GNT_D;
                     else if (gnt_i) state_d = GNT_I;
            GNT_I:   if (bus.i_ARB_mAck) state_d = RESP_I;
            GNT_D:   if (bus.i_ARB_mAck) state_d = RESP_D;
            RESP_I,
            RESP_D:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        bus.o_ARB_mReq = (state_q == GNT_I) || (state_q == GNT_D);
        bus.o_ARB_iAck = (state_q == RESP_I) && !killed_q;
        bus.o_ARB_dAck = (state_q == RESP_D);
    end

    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = bus.i_ARB_mRdata[7:0];
            2'd1:    ld_byte = bus.i_ARB_mRdata[15:8];
            2'd2:    ld_byte = bus.i_ARB_mRdata[23:16];
            default: ld_byte = bus.i_ARB_mRdata[31:24];
        endcase
    end

    // Datapath: memory fields latched at grant, read data latched on mAck.
    always_comb begin
        mWe_d    = mWe_q;
        mBe_d    = mBe_q;
        mAddr_d  = mAddr_q;
        mWdata_d = mWdata_q;
        lane_d   = lane_q;
        byte_d   = byte_q;
        iRdata_d = iRdata_q;
        dRdata_d = dRdata_q;
        killed_d = 1'b0;

        if (gnt_d) begin
            mWe_d   = bus.i_ARB_dWe;
            mAddr_d = {bus.i_ARB_dAddr[31:2], 2'b00};
            lane_d  = bus.i_ARB_dAddr[1:0];
            byte_d  = bus.i_ARB_dByte;
            if (bus.i_ARB_dWe && bus.i_ARB_dByte) begin
                mBe_d    = 4'(4'b0001 << bus.i_ARB_dAddr[1:0]);
                mWdata_d = {4{bus.i_ARB_dWdata[7:0]}};
            end else begin
                mBe_d    = 4'hF;
                mWdata_d = bus.i_ARB_dWdata;
            end
        end else if (gnt_i) begin
            mWe_d   = 1'b0;
            mBe_d   = 4'hF;
            mAddr_d = {bus.i_ARB_iAddr[31:2], 2'b00};
        end

        // Kill may arrive in the very cycle the memory completes.
        if (state_q == GNT_I) begin
            killed_d = killed_q | bus.i_ARB_iKill;
            if (bus.i_ARB_mAck && !killed_q && !bus.i_ARB_iKill)
                iRdata_d = bus.i_ARB_mRdata;
        end else if (state_q == RESP_I) begin
            killed_d = killed_q;
        end

        if (state_q == GNT_D && bus.i_ARB_mAck)
            dRdata_d = byte_q ? {24'h0, ld_byte} : bus.i_ARB_mRdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mWe_q    <= 1'b0;
            mBe_q    <= '0;
            mAddr_q  <= '0;
            mWdata_q <= '0;
            lane_q   <= '0;
            byte_q   <= 1'b0;
            iRdata_q <= '0;
            dRdata_q <= '0;
            killed_q <= 1'b0;
        end else begin
            mWe_q    <= mWe_d;
            mBe_q    <= mBe_d;
            mAddr_q  <= mAddr_d;
            mWdata_q <= mWdata_d;
            lane_q   <= lane_d;
            byte_q   <= byte_d;
            iRdata_q <= iRdata_d;
            dRdata_q <= dRdata_d;
            killed_q <= killed_d;
        end
    end

    assign bus.o_ARB_mWe    = mWe_q;
    assign bus.o_ARB_mBe    = mBe_q;
    assign bus.o_ARB_mAddr  = mAddr_q;
    assign bus.o_ARB_mWdata = mWdata_q;
    assign bus.o_ARB_iRdata = iRdata_q;
    assign bus.o_ARB_dRdata = dRdata_q;

    // Stall while any live request has not yet been acknowledged.
    assign bus.o_ARB_pause = (bus.i_ARB_iReq & ~bus.i_ARB_iKill & ~bus.o_ARB_iAck)
                           | (bus.i_ARB_dReq & ~bus.o_ARB_dAck);
endmodule

// File: tb/tb_umem_arb.sv
// tb_umem_arb -- directed bench for umem_arb: fetch, byte store/load,
// arbitration order, fetch kill, starvation order and async reset.
module tb_umem_arb;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    umem_arb_if bus ();
    umem_arb #(.STARVE_MAX(2)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] exp_seq;
        logic [5:0] got_seq;
        int         ngnt;

        bus.i_ARB_iReq = 0; bus.i_ARB_iAddr = 0; bus.i_ARB_iKill = 0;
        bus.i_ARB_dReq = 0; bus.i_ARB_dWe = 0; bus.i_ARB_dByte = 0;
        bus.i_ARB_dAddr = 0; bus.i_ARB_dWdata = 0;
        bus.i_ARB_mRdata = 0; bus.i_ARB_mAck = 0;

        // Reset state
        #12;
        chk("rst_mReq",   32'(bus.o_ARB_mReq), 0);
        chk("rst_mWe",    32'(bus.o_ARB_mWe), 0);
        chk("rst_mBe",    32'(bus.o_ARB_mBe), 0);
        chk("rst_mAddr",  bus.o_ARB_mAddr, 0);
        chk("rst_mWdata", bus.o_ARB_mWdata, 0);
        chk("rst_iAck",   32'(bus.o_ARB_iAck), 0);
        chk("rst_dAck",   32'(bus.o_ARB_dAck), 0);
        chk("rst_iRdata", bus.o_ARB_iRdata, 0);
        chk("rst_dRdata", bus.o_ARB_dRdata, 0);
        rstn = 1'b1;
        nxt();

        // Word fetch, memory acks in the first grant cycle
        bus.i_ARB_iReq = 1; bus.i_ARB_iAddr = 32'h0000_0104; #1;
        chk("f_pause0", 32'(bus.o_ARB_pause), 1);
        chk("f_mReq0",  32'(bus.o_ARB_mReq), 0);
        nxt();
        chk("f_mReq1",  32'(bus.o_ARB_mReq), 1);
        chk("f_mAddr",  bus.o_ARB_mAddr, 32'h104);
        chk("f_mBe",    32'(bus.o_ARB_mBe), 32'hF);
        chk("f_mWe",    32'(bus.o_ARB_mWe), 0);
        bus.i_ARB_mAck = 1; bus.i_ARB_mRdata = 32'h2402_0005; #1;
        chk("f_pause1", 32'(bus.o_ARB_pause), 1);
        nxt();
        bus.i_ARB_mAck = 0; #1;
        chk("f_iAck",   32'(bus.o_ARB_iAck), 1);
        chk("f_iRdata", bus.o_ARB_iRdata, 32'h2402_0005);
        chk("f_pause2", 32'(bus.o_ARB_pause), 0);
        nxt();
        bus.i_ARB_iReq = 0; #1;
        chk("f_iAck3",  32'(bus.o_ARB_iAck), 0);
        chk("f_pause3", 32'(bus.o_ARB_pause), 0);

        // Byte store then byte load at 0x203
        nxt();
        bus.i_ARB_dReq = 1; bus.i_ARB_dWe = 1; bus.i_ARB_dByte = 1;
        bus.i_ARB_dAddr = 32'h0000_0203; bus.i_ARB_dWdata = 32'h0000_00AB;
        nxt();
        chk("bs_mReq",   32'(bus.o_ARB_mReq), 1);
        chk("bs_mWe",    32'(bus.o_ARB_mWe), 1);
        chk("bs_mBe",    32'(bus.o_ARB_mBe), 32'h8);
        chk("bs_mWdata", bus.o_ARB_mWdata, 32'hABAB_ABAB);
        chk("bs_mAddr",  bus.o_ARB_mAddr, 32'h200);
        bus.i_ARB_mAck = 1; bus.i_ARB_mRdata = 0;
        nxt();
        bus.i_ARB_mAck = 0; #1;
        chk("bs_dAck", 32'(bus.o_ARB_dAck), 1);
        nxt();
        bus.i_ARB_dWe = 0; #1;
        chk("bl_dAck0", 32'(bus.o_ARB_dAck), 0);
        nxt();
        chk("bl_mReq", 32'(bus.o_ARB_mReq), 1);
        chk("bl_mWe",  32'(bus.o_ARB_mWe), 0);
        bus.i_ARB_mAck = 1; bus.i_ARB_mRdata = 32'hAB00_0000;
        nxt();
        bus.i_ARB_mAck = 0; #1;
        chk("bl_dAck",   32'(bus.o_ARB_dAck), 1);
        chk("bl_dRdata", bus.o_ARB_dRdata, 32'h0000_00AB);
        nxt();
        bus.i_ARB_dReq = 0; bus.i_ARB_dByte = 0;

        // Simultaneous requests: data first, fetch right after
        nxt();
        bus.i_ARB_dReq = 1; bus.i_ARB_dAddr = 32'h300;
        bus.i_ARB_iReq = 1; bus.i_ARB_iAddr = 32'h400; #1;
        chk("both_pause0", 32'(bus.o_ARB_pause), 1);
        nxt();
        chk("both_mAddrD", bus.o_ARB_mAddr, 32'h300);
        bus.i_ARB_mAck = 1; bus.i_ARB_mRdata = 32'h55AA_55AA;
        nxt();
        bus.i_ARB_mAck = 0; #1;
        chk("both_dAck",   32'(bus.o_ARB_dAck), 1);
        chk("both_iAck0",  32'(bus.o_ARB_iAck), 0);
        chk("both_dRdata", bus.o_ARB_dRdata, 32'h55AA_55AA);
        chk("both_pause2", 32'(bus.o_ARB_pause), 1);
        nxt();
        bus.i_ARB_dReq = 0; #1;
        chk("both_mReqIdle", 32'(bus.o_ARB_mReq), 0);
        chk("both_dAck1",    32'(bus.o_ARB_dAck), 0);
        chk("both_pause3",   32'(bus.o_ARB_pause), 1);
        nxt();
        chk("both_mReqI",  32'(bus.o_ARB_mReq), 1);
        chk("both_mAddrI", bus.o_ARB_mAddr, 32'h400);
        bus.i_ARB_mAck = 1; bus.i_ARB_mRdata = 32'h1234_5678;
        nxt();
        bus.i_ARB_mAck = 0; #1;
        chk("both_iAck",   32'(bus.o_ARB_iAck), 1);
        chk("both_dAck2",  32'(bus.o_ARB_dAck), 0);
        chk("both_iRdata", bus.o_ARB_iRdata, 32'h1234_5678);
        nxt();
        bus.i_ARB_iReq = 0; #1;
        chk("both_iAck1", 32'(bus.o_ARB_iAck), 0);

        // Fetch killed during a 3-cycle memory access
        nxt();
        bus.i_ARB_iReq = 1; bus.i_ARB_iAddr = 32'h500;
        nxt();
        chk("k_mReq1", 32'(bus.o_ARB_mReq), 1);
        bus.i_ARB_iKill = 1; #1;
        chk("k_pause", 32'(bus.o_ARB_pause), 0);
        nxt();
        bus.i_ARB_iKill = 0; bus.i_ARB_iReq = 0; #1;
        chk("k_mReq2", 32'(bus.o_ARB_mReq), 1);
        nxt();
        bus.i_ARB_mAck = 1; bus.i_ARB_mRdata = 32'hDEAD_BEEF;
        nxt();
        bus.i_ARB_mAck = 0; #1;
        chk("k_iAck",   32'(bus.o_ARB_iAck), 0);
        chk("k_iRdata", bus.o_ARB_iRdata, 32'h1234_5678);
        chk("k_mReq4",  32'(bus.o_ARB_mReq), 0);
        nxt();
        bus.i_ARB_iReq = 1; bus.i_ARB_iAddr = 32'h600;
        nxt();
        chk("k2_mAddr", bus.o_ARB_mAddr, 32'h600);
        bus.i_ARB_mAck = 1; bus.i_ARB_mRdata = 32'h0BAD_F00D;
        nxt();
        bus.i_ARB_mAck = 0; #1;
        chk("k2_iAck",   32'(bus.o_ARB_iAck), 1);
        chk("k2_iRdata", bus.o_ARB_iRdata, 32'h0BAD_F00D);
        nxt();
        bus.i_ARB_iReq = 0;
        nxt();

        // Both requests held: grant order (bit k = 1 means fetch on grant k)
`ifdef UMEM_ARB_FAIR_EN
        exp_seq = 6'b100100;
`else
        exp_seq = 6'b000000;
`endif
        got_seq = '0;
        ngnt = 0;
        bus.i_ARB_dReq = 1; bus.i_ARB_dWe = 0; bus.i_ARB_dAddr = 32'hD00;
        bus.i_ARB_iReq = 1; bus.i_ARB_iAddr = 32'h100;
        bus.i_ARB_mAck = 1; bus.i_ARB_mRdata = 32'h0;
        for (int c = 0; c < 30 && ngnt < 6; c++) begin
            nxt();
            if (bus.o_ARB_mReq === 1'b1) begin
                got_seq[ngnt] = (bus.o_ARB_mAddr == 32'h100);
                ngnt++;
            end
        end
        chk("fair_ngnt", 32'(ngnt), 6);
        for (int g = 0; g < 6; g++)
            chk($sformatf("fair_gnt%0d", g), 32'(got_seq[g]), 32'(exp_seq[g]));
        bus.i_ARB_dReq = 0; bus.i_ARB_iReq = 0;
        repeat (4) nxt();
        bus.i_ARB_mAck = 0;
        nxt();

        // Async reset in the middle of a data grant
        bus.i_ARB_dReq = 1; bus.i_ARB_dWe = 1; bus.i_ARB_dByte = 0;
        bus.i_ARB_dAddr = 32'h700; bus.i_ARB_dWdata = 32'hCAFE_F00D;
        nxt();
        chk("r_mReq1", 32'(bus.o_ARB_mReq), 1);
        #2 rstn = 1'b0;
        #1;
        chk("r_mReqAsync", 32'(bus.o_ARB_mReq), 0);
        chk("r_mWeAsync",  32'(bus.o_ARB_mWe), 0);
        chk("r_mBeAsync",  32'(bus.o_ARB_mBe), 0);
        nxt();
        bus.i_ARB_dReq = 0; #1;
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            nxt();
            chk($sformatf("r_dAck%0d", c), 32'(bus.o_ARB_dAck), 0);
            chk($sformatf("r_mReq%0d", c), 32'(bus.o_ARB_mReq), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
